sr_flag_arbiter: RTL

- Round-robin arbiter and sequencer that shares one bank of SR-style status flags between N_REQ requesters.
- Each requester issues one set, clear or read operation on one flag index.
- The arbiter serialises these operations, applies them with SR semantics, and acknowledges with the resulting flag value.
- Sits between control agents and the shared flag bank; the flag bank lives inside this block.

---
 rtl/sr_arb_pkg.sv | 17 +
 rtl/rr_picker.sv | 34 +++
 rtl/sr_flag_arbiter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/sr_arb_pkg.sv
// Shared types and op encodings for the SR flag arbiter.
// The grant-lock feature is compiled in with SR_ARB_LOCK_EN.
package sr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    ACK   = 2'd2
  } arb_state_t;

  // {S,R} encodings of one requester's op slice
  localparam logic [1:0] OP_SET = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b01;
  localparam logic [1:0] OP_RD  = 2'b00;
  localparam logic [1:0] OP_BAD = 2'b11;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector: first requester at or after ptr, wrapping
// from N_REQ-1 back to 0.
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [PTR_W-1:0] id,
  output logic             valid
);

  int j;

  // Scan from the farthest slot down so the nearest requester is assigned last.
  always_comb begin
    grant = '0;
    id    = '0;
    valid = 1'b0;
    j     = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (req[j]) begin
        grant    = '0;
        grant[j] = 1'b1;
        id       = PTR_W'(j);
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sr_flag_arbiter.sv
// Round-robin sequencer applying set/clear/read ops from N_REQ requesters to a
// shared SR flag bank. Defining SR_ARB_LOCK_EN adds the lock input.
module sr_flag_arbiter
  import sr_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int N_FLAGS = 8,
  parameter int IDX_W   = $clog2(N_FLAGS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [2*N_REQ-1:0]       op,
  input  logic [IDX_W*N_REQ-1:0]   idx,
`ifdef SR_ARB_LOCK_EN
  input  logic [N_REQ-1:0]         lock,
`endif
  output logic [N_REQ-1:0]         ack,
  output logic                     rd_q,
  output logic                     err,
  output logic                     busy,
  output logic [N_FLAGS-1:0]       flags,
  output logic [1:0]               dbg_state
);

  // Handshake: a requester raises req with stable op/idx and holds it until it
  // samples its ack bit high, dropping req on that same edge. req is only
  // looked at in IDLE, so the next IDLE cycle always sees a fresh request.

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int FI_W  = (N_FLAGS > 1) ? $clog2(N_FLAGS) : 1;
  localparam logic [IDX_W:0] NFL = (IDX_W + 1)'(N_FLAGS);

  arb_state_t         state;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   win_id;
  logic [N_REQ-1:0]   win_grant;
  logic [1:0]         op_l;
  logic [IDX_W-1:0]   idx_l;
  logic [N_FLAGS-1:0] flags_r;

  logic [N_REQ-1:0]   pick_grant;
  logic [PTR_W-1:0]   pick_id;
  logic               pick_valid;
  logic               in_range;
  logic [FI_W-1:0]    fidx;
  logic [PTR_W-1:0]   next_ptr;

  rr_picker #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_picker (
    .req   (req),
    .ptr   (ptr),
    .grant (pick_grant),
    .id    (pick_id),
    .valid (pick_valid)
  );

  assign in_range = ({1'b0, idx_l} < NFL);
  assign fidx     = FI_W'(idx_l);

  always_comb begin
    next_ptr = (int'(win_id) == N_REQ - 1) ? '0 : win_id + 1'b1;
`ifdef SR_ARB_LOCK_EN
    if (lock[win_id]) next_ptr = win_id;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      win_id    <= '0;
      win_grant <= '0;
      op_l      <= OP_RD;
      idx_l     <= '0;
      flags_r   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            win_id    <= pick_id;
            win_grant <= pick_grant;
            op_l      <= op[2*pick_id +: 2];
            idx_l     <= idx[IDX_W*pick_id +: IDX_W];
            state     <= APPLY;
          end
        end
        APPLY: begin
          // Out-of-range indices and OP_BAD leave the bank untouched.
          if (in_range) begin
            case (op_l)
              OP_SET:  flags_r[fidx] <= 1'b1;
              OP_CLR:  flags_r[fidx] <= 1'b0;
              default: ;
            endcase
          end
          state <= ACK;
        end
        ACK: begin
          ptr   <= next_ptr;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    ack  = '0;
    rd_q = 1'b0;
    err  = 1'b0;
    if (state == ACK) begin
      ack  = win_grant;
      rd_q = in_range & flags_r[fidx];
      err  = (op_l == OP_BAD) | ~in_range;
    end
  end

  assign busy      = (state != IDLE);
  assign flags     = flags_r;
  assign dbg_state = state;

endmodule
